gray_to_rgb_expander: RTL and testbench
=======================================

Name: gray_to_rgb_expander

Overview:
- Inverse-direction companion to the RGB-to-grayscale pipeline.
- Takes an 8-bit grayscale pixel stream and expands it into 16-bit red/green/blue channels, using the same channel width and upper-byte-significant convention.
- Two modes per pixel: plain replication (gray) or 4-segment piecewise-linear heat map; all arithmetic is shift/invert only.
- 3-stage valid/ready pipeline with global stall and a line-column counter that flags end-of-line on the output side.

Parameters:
- LINE_W, 640, pixels per line; out_eol asserts on the last column; legal range 2..65535.
- COL_W, $clog2(LINE_W), width of the internal column counter; derived, not overridden.

Ports:
- clk        input   1   rising-edge clock
- rst        input   1   asynchronous reset, active-high
- in_gray    input   8   grayscale pixel
- in_mode    input   1   0 = gray replicate, 1 = heat map; sampled with the pixel and carried down the pipe
- in_valid   input   1   in_gray/in_mode valid
- in_ready   output  1   block accepts a pixel this cycle
- out_red    output  16  red channel
- out_green  output  16  green channel
- out_blue   output  16  blue channel
- out_valid  output  1   output pixel valid
- out_ready  input   1   downstream accepts
- out_eol    output  1   current output pixel is the last of a line; qualified by out_valid

Behaviour:
- Reset (async, immediate):
  - all stage valids = 0, so out_valid = 0 and out_eol = 0
  - out_red/green/blue = 16'h0000
  - column counter = 0
  - pixels in flight are discarded, not flushed
- Advance:
  - advance = ~v3 | out_ready, where v3 is the stage-3 (output) valid.
  - in_ready = advance (combinational from out_ready; no registered skid).
  - When advance=1, every stage shifts: v1 <= in_valid, v2 <= v1, v3 <= v2.
  - Bubbles travel with the pipe and are not collapsed.
  - When advance=0, all stages and outputs hold exactly; outputs stay stable while out_valid & ~out_ready.
- Latency and throughput: 3 cycles from accept (in_valid & in_ready) to out_valid, assuming out_ready held high. Throughput is 1 pixel/cycle.
- Stage 1 registers:
  - g = in_gray, mode = in_mode
  - seg = g[7:6]
  - ramp = {g[5:0], 2'b00}
- Stage 2 computes the 8-bit channels c_r, c_g, c_b. Let down = ~ramp (equals 255 - ramp).
  - mode 0: c_r = c_g = c_b = g
  - mode 1, seg 0: R = 00,   G = ramp, B = FF
  - mode 1, seg 1: R = 00,   G = FF,   B = down
  - mode 1, seg 2: R = ramp, G = FF,   B = 00
  - mode 1, seg 3: R = FF,   G = down, B = 00
- Stage 3: out_x = {c_x, c_x}, so 8'hFF maps to 16'hFFFF and 8'h00 to 16'h0000.
- Column counter:
  - Increments on each output handshake (out_valid & out_ready).
  - Wraps from LINE_W-1 to 0.
  - out_eol = out_valid & (col == LINE_W-1), combinational from the registered counter.
  - out_eol holds with the pixel during a stall.
- Mode changes: in_mode may change on any accepted pixel; each pixel uses its own sampled mode, with no cross-pixel effect.
- No overflow is possible: all arithmetic is bit-select, concatenation or inversion.

Decomposition:
- Package gray_color_pkg holds:
  - PIX_W = 8, CH_W = 16
  - MODE_GRAY = 1'b0, MODE_HEAT = 1'b1
  - segment constants SEG_0..SEG_3
- Sub-module gray_heat_map: combinational stage-2 mapping, (g, mode) -> (c_r, c_g, c_b). It is instantiated once and unit-testable exhaustively over 512 input combinations.

Test Plan:
- Gray, full throughput: mode 0, out_ready=1, in_gray=8'h80 -> 3 cycles later out_red = out_green = out_blue = 16'h8080, out_valid=1 for one cycle.
- Heat-map corners (mode 1), one at a time; each reading is {R, G, B}:
  - 8'h00 -> {0000, 0000, FFFF}
  - 8'h40 -> {0000, FFFF, FFFF}
  - 8'h7F -> {0000, FFFF, 0303}
  - 8'hC0 -> {FFFF, FFFF, 0000}
  - 8'hFF -> {FFFF, 0303, 0000}
  - Also check all 256 values against the reference model.
- Backpressure: stream 8'h10, 8'h20, 8'h30; hold out_ready=0 for 5 cycles once out_valid=1.
  - in_ready is low and outputs are stable during the hold.
  - On release, exactly 1010, 2020, 3030 in order, with no loss or duplication.
- EOL: LINE_W=4, 9 pixels with random out_ready -> out_eol high on output pixels #4 and #8 only.
- Reset mid-stream: assert rst with 3 pixels in flight.
  - out_valid drops and outputs read 0 before the next clk edge.
  - After release, the first pixel is column 0 (LINE_W=4: eol on its 4th).
- Mode interleave: alternate mode 0/1 with in_gray=8'hC0 each cycle -> outputs alternate C0C0×3 and {FFFF, FFFF, 0000}.

Source files
------------

// File: rtl/gray_color_pkg.sv
// gray_color_pkg: shared widths, mode codes and heat-map segment codes
package gray_color_pkg;
    localparam int PIX_W = 8;
    localparam int CH_W  = 16;

    localparam logic MODE_GRAY = 1'b0;
    localparam logic MODE_HEAT = 1'b1;

    localparam logic [1:0] SEG_0 = 2'd0;
    localparam logic [1:0] SEG_1 = 2'd1;
    localparam logic [1:0] SEG_2 = 2'd2;
    localparam logic [1:0] SEG_3 = 2'd3;

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [CH_W-1:0]  ch_t;
endpackage

// File: rtl/gray_heat_map.sv
// gray_heat_map: combinational gray -> 8-bit RGB mapping (replicate or 4-segment heat map)
module gray_heat_map
    import gray_color_pkg::*;
(
    input  logic [PIX_W-1:0] g,
    input  logic             mode,
    output logic [PIX_W-1:0] c_r,
    output logic [PIX_W-1:0] c_g,
    output logic [PIX_W-1:0] c_b
);
    logic [1:0]       seg;
    logic [PIX_W-1:0] ramp;
    logic [PIX_W-1:0] down;

    always_comb begin
        seg  = g[7:6];
        ramp = {g[5:0], 2'b00};
        down = ~ramp;
        c_r  = (mode == MODE_GRAY) ? g : (seg == SEG_2) ? ramp : (seg == SEG_3) ? 8'hFF : 8'h00;
        c_g  = (mode == MODE_GRAY) ? g : (seg == SEG_0) ? ramp : (seg == SEG_3) ? down  : 8'hFF;
        c_b  = (mode == MODE_GRAY) ? g : (seg == SEG_0) ? 8'hFF : (seg == SEG_1) ? down  : 8'h00;
    end
endmodule

// File: rtl/gray_to_rgb_expander.sv
// gray_to_rgb_expander: 3-stage stallable pipeline expanding 8-bit gray to 16-bit RGB,
// with an output-side column counter that flags end-of-line.
module gray_to_rgb_expander
    import gray_color_pkg::*;
#(
    parameter int LINE_W = 640
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] in_gray,
    input  logic             in_mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [CH_W-1:0]  out_red,
    output logic [CH_W-1:0]  out_green,
    output logic [CH_W-1:0]  out_blue,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_eol
);
    localparam int COL_W = $clog2(LINE_W);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W - 1);

    logic             adv;
    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [PIX_W-1:0] g1_q, g1_d;
    logic             m1_q, m1_d;
    logic [PIX_W-1:0] r2_q, r2_d, gc2_q, gc2_d, b2_q, b2_d;
    logic [CH_W-1:0]  r3_q, r3_d, gc3_q, gc3_d, b3_q, b3_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [PIX_W-1:0] c_r, c_g, c_b;

    gray_heat_map u_map (
        .g    (g1_q),
        .mode (m1_q),
        .c_r  (c_r),
        .c_g  (c_g),
        .c_b  (c_b)
    );

    assign adv       = ~v3_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign out_red   = r3_q;
    assign out_green = gc3_q;
    assign out_blue  = b3_q;
    assign out_eol   = v3_q & (col_q == LAST_COL);

    // Whole pipe shifts together; bubbles are carried, never squeezed out.
    always_comb begin
        v1_d  = adv ? in_valid : v1_q;
        g1_d  = adv ? in_gray : g1_q;
        m1_d  = adv ? in_mode : m1_q;
        v2_d  = adv ? v1_q : v2_q;
        r2_d  = adv ? c_r : r2_q;
        gc2_d = adv ? c_g : gc2_q;
        b2_d  = adv ? c_b : b2_q;
        v3_d  = adv ? v2_q : v3_q;
        r3_d  = adv ? {r2_q, r2_q} : r3_q;
        gc3_d = adv ? {gc2_q, gc2_q} : gc3_q;
        b3_d  = adv ? {b2_q, b2_q} : b3_q;
        col_d = !(v3_q && out_ready) ? col_q : (col_q == LAST_COL) ? '0 : col_q + COL_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            g1_q  <= '0;
            m1_q  <= 1'b0;
            r2_q  <= '0;
            gc2_q <= '0;
            b2_q  <= '0;
            r3_q  <= '0;
            gc3_q <= '0;
            b3_q  <= '0;
            col_q <= '0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            v3_q  <= v3_d;
            g1_q  <= g1_d;
            m1_q  <= m1_d;
            r2_q  <= r2_d;
            gc2_q <= gc2_d;
            b2_q  <= b2_d;
            r3_q  <= r3_d;
            gc3_q <= gc3_d;
            b3_q  <= b3_d;
            col_q <= col_d;
        end
    end
endmodule

// File: tb/tb_gray_to_rgb_expander.sv
// tb_gray_to_rgb_expander: directed + random stimulus against an arithmetic colour model
// and an expected-pixel queue, with LINE_W = 4 so end-of-line is exercised often.
module tb_gray_to_rgb_expander;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_gray;
    logic        in_mode;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_red, out_green, out_blue;
    logic        out_valid;
    logic        out_ready;
    logic        out_eol;

    int total = 0;
    int bad = 0;
    int col_m = 0;
    int eol_hs = 0;
    logic [47:0] q[$];

    gray_to_rgb_expander #(.LINE_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_gray   (in_gray),
        .in_mode   (in_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_red   (out_red),
        .out_green (out_green),
        .out_blue  (out_blue),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_eol   (out_eol)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] ref_rgb(int g, bit m);
        int r, gr, b, ramp;
        ramp = (g % 64) * 4;
        if (!m) begin
            r = g; gr = g; b = g;
        end else if (g < 64) begin
            r = 0; gr = ramp; b = 255;
        end else if (g < 128) begin
            r = 0; gr = 255; b = 255 - ramp;
        end else if (g < 192) begin
            r = ramp; gr = 255; b = 0;
        end else begin
            r = 255; gr = 255 - ramp; b = 0;
        end
        return {16'(r * 257), 16'(gr * 257), 16'(b * 257)};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model, update the model, advance to next negedge.
    task automatic tick();
        #1;
        chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
        if (out_valid) begin
            if (q.size() == 0) chk("extra_out", 64'(out_valid), 64'(0));
            else begin
                chk("rgb", 64'({out_red, out_green, out_blue}), 64'(q[0]));
                chk("eol", 64'(out_eol), 64'(col_m == 3));
                if (out_ready) begin
                    void'(q.pop_front());
                    if (out_eol) eol_hs++;
                    col_m = (col_m + 1) % 4;
                end
            end
        end else chk("eol_idle", 64'(out_eol), 64'(0));
        if (in_valid && in_ready) q.push_back(ref_rgb(int'(in_gray), in_mode));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_one(logic [7:0] g, logic m, logic [47:0] exp);
        int n;
        in_gray = g; in_mode = m; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'(3));
        chk("corner", 64'({out_red, out_green, out_blue}), 64'(exp));
        tick();
        chk("one_cycle", 64'(out_valid), 64'(0));
    endtask

    task automatic push_rand_ready(logic [7:0] g, logic m);
        int n;
        logic acc;
        in_gray = g; in_mode = m; in_valid = 1'b1;
        n = 0;
        do begin
            out_ready = 1'($urandom % 2);
            #1;
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("accept_timeout", 64'(acc), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'(0));
    endtask

    initial begin
        logic [47:0] hold;
        int n;
        rst = 1'b1; in_gray = '0; in_mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_eol", 64'(out_eol), 64'(0));
        chk("rst_rgb", 64'({out_red, out_green, out_blue}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        send_one(8'h80, 1'b0, 48'h8080_8080_8080);
        send_one(8'h00, 1'b1, 48'h0000_0000_FFFF);
        send_one(8'h40, 1'b1, 48'h0000_FFFF_FFFF);
        send_one(8'h7F, 1'b1, 48'h0000_FFFF_0303);
        send_one(8'hC0, 1'b1, 48'hFFFF_FFFF_0000);
        send_one(8'hFF, 1'b1, 48'hFFFF_0303_0000);

        // Mode interleave at full rate.
        out_ready = 1'b1; in_valid = 1'b1; in_gray = 8'hC0;
        for (int i = 0; i < 6; i++) begin
            in_mode = 1'(i % 2);
            tick();
        end
        drain();

        // Backpressure with three pixels filling the pipe.
        out_ready = 1'b1; in_valid = 1'b1;
        in_gray = 8'h10; in_mode = 1'b0; tick();
        in_gray = 8'h20; tick();
        in_gray = 8'h30; tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        hold = {out_red, out_green, out_blue};
        chk("bp_front", 64'(hold), 64'(48'h1010_1010_1010));
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_gray = 8'hEE;
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_stable", 64'({out_red, out_green, out_blue}), 64'(hold));
            chk("bp_valid", 64'(out_valid), 64'(1));
            tick();
        end
        in_valid = 1'b0;
        chk("bp_queue", 64'(q.size()), 64'(3));
        drain();

        // Asynchronous reset with pixels in flight, then end-of-line from column 0.
        out_ready = 1'b1; in_valid = 1'b1; in_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_gray = 8'(8'h50 + i);
            tick();
        end
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'(0));
        chk("arst_eol", 64'(out_eol), 64'(0));
        chk("arst_rgb", 64'({out_red, out_green, out_blue}), 64'(0));
        q.delete();
        col_m = 0;
        eol_hs = 0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) push_rand_ready(8'($urandom), 1'($urandom % 2));
        drain();
        chk("eol_count", 64'(eol_hs), 64'(2));

        // Every heat-map value under random backpressure.
        for (int i = 0; i < 256; i++) push_rand_ready(8'(i), 1'b1);
        drain();

        // Fully random traffic.
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'($urandom % 4 != 0);
            in_gray = 8'($urandom);
            in_mode = 1'($urandom % 2);
            out_ready = 1'($urandom % 3 != 0);
            tick();
        end
        drain();

        n = 0;
        while (out_valid && n < 5) begin
            tick();
            n++;
        end
        chk("final_idle", 64'(out_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
